wrf_src_check: RTL
==================

// Module: wrf_src_check
// PURPOSE
//  Receive-side test checker for the WR fabric 16-bit streaming interface.
//  Consumes frames the WR core delivers on its source port, parses the
//  Eth/IPv4/UDP header, filters on dest MAC and UDP port, and checks the payload
//  against a fixed word. Reports per-frame status and keeps saturating counters.
//  It is the loopback partner of the sink-side test frame generator.
// PARAMETERS
//  MAC_ADDR     48'h74563c4f4c6d  station MAC accepted as destination
//  ACCEPT_BCAST 1                 1: also accept dest ff:ff:ff:ff:ff:ff
//  UDP_PORT     16'h1000          required UDP destination port
//  PAYLOAD_WORD 16'h1234          expected value of every payload word
//  MAX_PAYLOAD  1024              max payload words (<=2046) before oversize error
// PORTS
//  wrf_clk       in   1   fabric clock; all logic on rising edge
//  wrf_rst_n     in   1   async active-low reset
//  wrf_valid     in   1   data word valid
//  wrf_last      in   1   final word of frame (qualified by wrf_valid)
//  wrf_data      in   16  frame word, MSB first; dst MAC is word 0
//  wrf_ready     out  1   sink can accept; transfer = wrf_valid & wrf_ready
//  stall         in   1   test backpressure; forces wrf_ready low
//  frm_done      out  1   1-cycle pulse: frame verdict valid
//  frm_ok        out  1   frame passed all checks (held until next frm_done)
//  frm_err_code  out  3   first error seen (held until next frm_done)
//  frm_len       out  11  payload words in last frame (held)
//  good_cnt      out  32  frames with frm_ok=1, saturating
//  bad_cnt       out  32  frames with frm_ok=0, saturating
// BEHAVIOUR
//  - Reset: state IDLE, word idx 0, frm_done/frm_ok 0, frm_err_code 0,
//    frm_len 0, counters 0. wrf_ready = ~stall (combinational, state != REPORT).
//  - States: IDLE -> HDR on first transfer -> PAY at word 21 -> REPORT on
//    transfer with wrf_last (from any of IDLE/HDR/PAY) -> IDLE next cycle.
//    REPORT lasts exactly 1 cycle; wrf_ready=0 there (1-cycle gap between frames).
//  - Word index counts transfers only; valid gaps and stalls do not advance it.
//  - Word map: 0-2 dst MAC, 3-5 src MAC, 6 EtherType, 7-16 IPv4, 17 UDP src,
//    18 UDP dst, 19 UDP len, 20 UDP csum, 21.. payload.
//  - Checks / err codes (first error latched, later ones ignored):
//    1 dst MAC != MAC_ADDR (and != bcast when ACCEPT_BCAST)
//    2 word6 != 16'h0800
//    3 word7[15:8] != 8'h45 or word11[7:0] != 8'h11 (not IPv4/UDP)
//    4 word18 != UDP_PORT
//    5 runt: wrf_last on word idx < 21 (no payload)
//    6 payload word != PAYLOAD_WORD
//    7 payload words > MAX_PAYLOAD
//    0 no error. IPv4/UDP checksums and length fields not checked.
//  - Frame with an error is still consumed to wrf_last; never drops ready.
//  - frm_len = payload word count, saturates at 2047; runt gives 0.
//  - REPORT cycle: frm_done=1, frm_ok=(code==0), code/len registered same cycle;
//    good_cnt or bad_cnt +1 same edge, holds at 32'hffffffff.
//  - Latency: verdict appears on cycle after the wrf_last transfer.
//  - Async reset mid-frame: abort, no verdict, counters cleared; next transfer
//    after release is treated as word 0 (remainder of cut frame reports error).
//  - wrf_data/wrf_last ignored when no transfer occurs.
// TESTING
//  1 127-word frame: MAC 74563c4f4c6d, 0800, 4500..3F11.., port 1000, 106x1234
//    -> frm_done 1 cycle after last, frm_ok=1, code 0, len 106, good_cnt=1.
//  2 same frame, word2=4c6e -> ok=0, code 1, bad_cnt=1; bcast dst -> ok=1.
//  3 payload word 50 = 1235 and port=2000 -> code 4 (first error wins), len 106.
//  4 10-word frame with last -> code 5, len 0; 1-word frame -> code 5.
//  5 frame 1 with random valid gaps + stall toggles -> identical verdict;
//    ready low in REPORT; two back-to-back frames -> good_cnt=2.
//  6 reset at word 60, release, send rest then full frame -> 1st verdict
//    code 1, 2nd ok; counters 0 after reset, bad=1 good=1 at end.

Source files
------------

// File: rtl/wrf_src_check.sv
// wrf_src_check: WR fabric receive checker that parses Eth/IPv4/UDP headers, filters frames, checks the payload and reports a verdict per frame.
module wrf_src_check #(
   parameter logic [47:0] MAC_ADDR     = 48'h74563c4f4c6d,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] UDP_PORT     = 16'h1000,
   parameter logic [15:0] PAYLOAD_WORD = 16'h1234,
   parameter int          MAX_PAYLOAD  = 1024
) (
   input  logic        wrf_clk,
   input  logic        wrf_rst_n,
   input  logic        wrf_valid,
   input  logic        wrf_last,
   input  logic [15:0] wrf_data,
   output logic        wrf_ready,
   input  logic        stall,
   output logic        frm_done,
   output logic        frm_ok,
   output logic [2:0]  frm_err_code,
   output logic [10:0] frm_len,
   output logic [31:0] good_cnt,
   output logic [31:0] bad_cnt
);
   typedef enum logic [1:0] {IDLE, HDR, PAY, REPORT} state_t;
   localparam logic [10:0] MAXP = 11'(MAX_PAYLOAD);
   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [10:0] plen_q, plen_d, plen_inc;
   logic [2:0]  err_q, err_d, werr, fin;
   logic        uc_q, uc_d, bc_q, bc_d;
   logic        done_q, ok_q;
   logic [2:0]  code_q;
   logic [10:0] len_q;
   logic [31:0] good_q, bad_q;
   logic        xfer, eop, in_pay, uc_w, bc_w;
   assign wrf_ready = ~stall & (state_q != REPORT);
   assign xfer      = wrf_valid & wrf_ready;
   assign eop       = xfer & wrf_last;
   assign in_pay    = idx_q == 5'd21;
   assign plen_inc  = in_pay ? plen_q + {10'd0, plen_q != 11'h7ff} : plen_q;
   assign uc_w      = wrf_data == (idx_q == 5'd0 ? MAC_ADDR[47:32] : idx_q == 5'd1 ? MAC_ADDR[31:16] : MAC_ADDR[15:0]);
   assign bc_w      = wrf_data == 16'hffff;
   // uc_q/bc_q carry the running match of dst MAC words 0-1; word 2 decides
   assign werr = in_pay ? (wrf_data != PAYLOAD_WORD ? 3'd6 : plen_q >= MAXP ? 3'd7 : 3'd0)
               : (idx_q == 5'd2 && !(uc_q && uc_w) && !(ACCEPT_BCAST && bc_q && bc_w)) ? 3'd1
               : (idx_q == 5'd6 && wrf_data != 16'h0800) ? 3'd2
               : ((idx_q == 5'd7 && wrf_data[15:8] != 8'h45) || (idx_q == 5'd11 && wrf_data[7:0] != 8'h11)) ? 3'd3
               : (idx_q == 5'd18 && wrf_data != UDP_PORT) ? 3'd4
               : wrf_last ? 3'd5 : 3'd0;
   assign fin  = err_q != 3'd0 ? err_q : werr;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      plen_d  = plen_q;
      err_d   = err_q;
      uc_d    = uc_q;
      bc_d    = bc_q;
      if (state_q == REPORT) state_d = IDLE;
      else if (xfer) begin
         state_d = wrf_last ? REPORT : (idx_q >= 5'd20 ? PAY : HDR);
         idx_d   = wrf_last ? 5'd0 : idx_q + {4'd0, !in_pay};
         plen_d  = wrf_last ? 11'd0 : plen_inc;
         err_d   = wrf_last ? 3'd0 : fin;
         uc_d    = (idx_q == 5'd0 || uc_q) && uc_w;
         bc_d    = (idx_q == 5'd0 || bc_q) && bc_w;
      end
   end
   always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
      if (!wrf_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         plen_q  <= '0;
         err_q   <= '0;
         uc_q    <= 1'b0;
         bc_q    <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         code_q  <= '0;
         len_q   <= '0;
         good_q  <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         plen_q  <= plen_d;
         err_q   <= err_d;
         uc_q    <= uc_d;
         bc_q    <= bc_d;
         done_q  <= eop;
         if (eop) begin
            ok_q   <= fin == 3'd0;
            code_q <= fin;
            len_q  <= in_pay ? plen_inc : 11'd0;
            if (fin == 3'd0) good_q <= good_q + {31'd0, good_q != 32'hffffffff};
            else bad_q <= bad_q + {31'd0, bad_q != 32'hffffffff};
         end
      end
   end
   assign frm_done     = done_q;
   assign frm_ok       = ok_q;
   assign frm_err_code = code_q;
   assign frm_len      = len_q;
   assign good_cnt     = good_q;
   assign bad_cnt      = bad_q;
endmodule
